drlp_dma_arbiter: RTL and testbench

- Shares the single DRAM port of the DRLP core among three requesters: image-read (img), weight-read (wgt) and result-write (res).
- Each requester asks for a burst (base word address + length). The arbiter grants bursts round-robin, drives the DRAM read/write port one word per beat, and routes returned read data back to the owning requester.
- It sits between the DRLP datapath buffers and the DRAM model/controller.

---
 rtl/drlp_dma_arbiter_if.sv | 56 +++++
 rtl/drlp_dma_arbiter.sv | 138 +++++++++++++
 tb/tb_drlp_dma_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/drlp_dma_arbiter_if.sv
// drlp_dma_arbiter_if: requester channels and DRAM port of the DRLP DMA arbiter
interface drlp_dma_arbiter_if #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int LEN_W = 12
);
  logic             img_req;
  logic [AW-1:0]    img_addr;
  logic [LEN_W-1:0] img_len;
  logic             img_gnt;
  logic [DW-1:0]    img_rd_data;
  logic             img_rd_valid;
  logic             img_done;
  logic             wgt_req;
  logic [AW-1:0]    wgt_addr;
  logic [LEN_W-1:0] wgt_len;
  logic             wgt_gnt;
  logic [DW-1:0]    wgt_rd_data;
  logic             wgt_rd_valid;
  logic             wgt_done;
  logic             res_req;
  logic [AW-1:0]    res_addr;
  logic [LEN_W-1:0] res_len;
  logic             res_gnt;
  logic [DW-1:0]    res_wr_data;
  logic             res_wr_valid;
  logic             res_wr_ready;
  logic             res_done;
  logic             dma_rd_en;
  logic [AW-1:0]    dma_rd_addr;
  logic [DW-1:0]    dma_rd_data;
  logic             dma_rd_ready;
  logic             dma_wr_en;
  logic [AW-1:0]    dma_wr_addr;
  logic [DW-1:0]    dma_wr_data;
  logic             busy;
  logic             err;
  modport slave (
    input  img_req, img_addr, img_len, wgt_req, wgt_addr, wgt_len,
           res_req, res_addr, res_len, res_wr_data, res_wr_valid,
           dma_rd_data, dma_rd_ready,
    output img_gnt, img_rd_data, img_rd_valid, img_done,
           wgt_gnt, wgt_rd_data, wgt_rd_valid, wgt_done,
           res_gnt, res_wr_ready, res_done,
           dma_rd_en, dma_rd_addr, dma_wr_en, dma_wr_addr, dma_wr_data, busy, err
  );
  modport master (
    output img_req, img_addr, img_len, wgt_req, wgt_addr, wgt_len,
           res_req, res_addr, res_len, res_wr_data, res_wr_valid,
           dma_rd_data, dma_rd_ready,
    input  img_gnt, img_rd_data, img_rd_valid, img_done,
           wgt_gnt, wgt_rd_data, wgt_rd_valid, wgt_done,
           res_gnt, res_wr_ready, res_done,
           dma_rd_en, dma_rd_addr, dma_wr_en, dma_wr_addr, dma_wr_data, busy, err
  );
endinterface

// File: rtl/drlp_dma_arbiter.sv
// drlp_dma_arbiter: round-robin burst arbiter sharing one DRAM port among img/wgt reads and res writes
module drlp_dma_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int LEN_W   = 12,
  parameter int MAX_OUT = 4
) (
  input logic i_clk,
  input logic i_rst,
  drlp_dma_arbiter_if.slave bus
);
  localparam int OW = $clog2(MAX_OUT + 1);
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR} state_t;
  state_t           state;
  logic [1:0]       ptr, win;
  logic             owner, ret_ok, issue, accept, gnt_any;
  logic [AW-1:0]    addr, gaddr;
  logic [LEN_W-1:0] rem, ret_left, glen;
  logic [OW-1:0]    outst, out_after;
  logic [2:0]       req;
  logic [DW-1:0]    rd_word;
  always_comb begin
    req = {bus.res_req, bus.wgt_req, bus.img_req};
    win = 2'd3;
    for (int k = 3; k >= 1; k--)
      if (req[2'((int'(ptr) + k) % 3)]) win = 2'((int'(ptr) + k) % 3);
    gaddr = win == 2'd2 ? bus.res_addr : win == 2'd1 ? bus.wgt_addr : bus.img_addr;
    glen = win == 2'd2 ? bus.res_len : win == 2'd1 ? bus.wgt_len : bus.img_len;
    gnt_any = bus.img_gnt | bus.wgt_gnt | bus.res_gnt;
    rd_word = bus.dma_rd_data;
    ret_ok = bus.dma_rd_ready && outst != '0;
    out_after = outst - OW'(ret_ok);
    issue = state == RD_ISSUE && rem != '0 && out_after < OW'(MAX_OUT);
    accept = state == WR && bus.res_wr_valid && bus.res_wr_ready;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      ptr <= 2'd2;
      owner <= 1'b0;
      addr <= '0;
      rem <= '0;
      ret_left <= '0;
      outst <= '0;
      bus.img_gnt <= 1'b0;
      bus.img_rd_data <= '0;
      bus.img_rd_valid <= 1'b0;
      bus.img_done <= 1'b0;
      bus.wgt_gnt <= 1'b0;
      bus.wgt_rd_data <= '0;
      bus.wgt_rd_valid <= 1'b0;
      bus.wgt_done <= 1'b0;
      bus.res_gnt <= 1'b0;
      bus.res_wr_ready <= 1'b0;
      bus.res_done <= 1'b0;
      bus.dma_rd_en <= 1'b0;
      bus.dma_rd_addr <= '0;
      bus.dma_wr_en <= 1'b0;
      bus.dma_wr_addr <= '0;
      bus.dma_wr_data <= '0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.img_gnt <= 1'b0;
      bus.wgt_gnt <= 1'b0;
      bus.res_gnt <= 1'b0;
      bus.img_rd_valid <= 1'b0;
      bus.wgt_rd_valid <= 1'b0;
      bus.img_done <= 1'b0;
      bus.wgt_done <= 1'b0;
      bus.res_done <= 1'b0;
      bus.dma_rd_en <= 1'b0;
      bus.dma_wr_en <= 1'b0;
      outst <= out_after + OW'(issue);
      if (bus.dma_rd_ready && outst == '0) bus.err <= 1'b1;
      // returns are routed to the burst owner in issue order; no tags needed
      if (ret_ok) begin
        ret_left <= ret_left - LEN_W'(1);
        if (owner) begin
          bus.wgt_rd_data <= rd_word;
          bus.wgt_rd_valid <= 1'b1;
          bus.wgt_done <= ret_left == LEN_W'(1);
        end else begin
          bus.img_rd_data <= rd_word;
          bus.img_rd_valid <= 1'b1;
          bus.img_done <= ret_left == LEN_W'(1);
        end
      end
      if (issue) begin
        bus.dma_rd_en <= 1'b1;
        bus.dma_rd_addr <= addr;
        addr <= addr + AW'(1);
        rem <= rem - LEN_W'(1);
      end
      case (state)
        // a grant pulse still showing blocks re-arbitration of the held request
        IDLE: if (win != 2'd3 && !gnt_any) begin
          ptr <= win;
          addr <= gaddr;
          rem <= glen;
          ret_left <= glen;
          owner <= win == 2'd1;
          bus.img_gnt <= win == 2'd0;
          bus.wgt_gnt <= win == 2'd1;
          bus.res_gnt <= win == 2'd2;
          if (glen == '0) begin
            bus.img_done <= win == 2'd0;
            bus.wgt_done <= win == 2'd1;
            bus.res_done <= win == 2'd2;
          end else begin
            state <= win == 2'd2 ? WR : RD_ISSUE;
            bus.busy <= 1'b1;
            bus.res_wr_ready <= win == 2'd2;
          end
        end
        RD_ISSUE: if (issue && rem == LEN_W'(1)) state <= RD_DRAIN;
        RD_DRAIN: if (outst == '0) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        WR: if (accept) begin
          bus.dma_wr_en <= 1'b1;
          bus.dma_wr_addr <= addr;
          bus.dma_wr_data <= bus.res_wr_data;
          addr <= addr + AW'(1);
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            bus.res_done <= 1'b1;
            bus.res_wr_ready <= 1'b0;
            bus.busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drlp_dma_arbiter.sv
// tb_drlp_dma_arbiter: scoreboard bench with a DRAM model and a round-robin grant-order model
module tb_drlp_dma_arbiter;
  localparam int MAX_OUT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  drlp_dma_arbiter_if #(.DW(32), .AW(32), .LEN_W(12)) bus();
  drlp_dma_arbiter #(.DW(32), .AW(32), .LEN_W(12), .MAX_OUT(MAX_OUT)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus(bus)
  );
  typedef struct {logic [31:0] d; bit last; bit zero;} rd_t;
  typedef struct {logic [31:0] a; logic [31:0] d; bit last; bit zero;} wr_t;
  typedef struct {longint due; logic [31:0] a;} pend_t;
  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  int lat = 2;
  int last_gnt = 2;
  int exp_gnt[$];
  rd_t exp_img[$];
  rd_t exp_wgt[$];
  wr_t exp_wr[$];
  pend_t pend[$];
  logic [31:0] wr_data_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h0123_4567;
  endfunction
  function automatic logic outs_any();
    return |{bus.img_gnt, bus.img_rd_data, bus.img_rd_valid, bus.img_done,
             bus.wgt_gnt, bus.wgt_rd_data, bus.wgt_rd_valid, bus.wgt_done,
             bus.res_gnt, bus.res_wr_ready, bus.res_done, bus.dma_rd_en, bus.dma_rd_addr,
             bus.dma_wr_en, bus.dma_wr_addr, bus.dma_wr_data, bus.busy, bus.err};
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic check_rd(input int ch, input logic v, input logic [31:0] d, input logic dn, input logic g);
    rd_t e;
    string nm;
    nm = ch == 0 ? "img" : "wgt";
    if ((ch == 0 ? exp_img.size() : exp_wgt.size()) == 0) begin
      chk({nm, "_unexpected_valid_done"}, {v, dn}, 0);
    end else begin
      e = ch == 0 ? exp_img.pop_front() : exp_wgt.pop_front();
      chk({nm, "_rd_valid"}, v, !e.zero);
      if (!e.zero) chk({nm, "_rd_data"}, d, e.d);
      chk({nm, "_done"}, dn, e.last);
      if (e.zero) chk({nm, "_len0_gnt_with_done"}, g, 1);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.img_gnt || bus.wgt_gnt || bus.res_gnt) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", {bus.res_gnt, bus.wgt_gnt, bus.img_gnt}, 0);
        else chk("gnt_order", {bus.res_gnt, bus.wgt_gnt, bus.img_gnt}, 64'd1 << exp_gnt.pop_front());
      end
      if (bus.img_rd_valid || bus.img_done) check_rd(0, bus.img_rd_valid, bus.img_rd_data, bus.img_done, bus.img_gnt);
      if (bus.wgt_rd_valid || bus.wgt_done) check_rd(1, bus.wgt_rd_valid, bus.wgt_rd_data, bus.wgt_done, bus.wgt_gnt);
      if (bus.dma_wr_en || bus.res_done) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", {bus.dma_wr_en, bus.res_done}, 0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("dma_wr_en", bus.dma_wr_en, !e.zero);
          if (!e.zero) begin
            chk("dma_wr_addr", bus.dma_wr_addr, e.a);
            chk("dma_wr_data", bus.dma_wr_data, e.d);
          end
          chk("res_done", bus.res_done, e.last);
          if (e.zero) chk("res_len0_gnt_with_done", bus.res_gnt, 1);
        end
      end
      if (bus.dma_rd_en || bus.dma_wr_en) chk("rd_wr_exclusive", bus.dma_rd_en & bus.dma_wr_en, 0);
    end
  end
  // DRAM model: fixed latency per batch, returns in issue order, one per cycle
  initial begin
    bus.dma_rd_ready = 1'b0;
    bus.dma_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.dma_rd_en) begin
        pend.push_back('{cyc + longint'(lat), bus.dma_rd_addr});
        chk("outstanding_le_max", pend.size() <= MAX_OUT, 1);
      end
      bus.dma_rd_ready = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.dma_rd_ready = 1'b1;
        bus.dma_rd_data = mem(pend[0].a);
        void'(pend.pop_front());
      end
    end
  end
  task automatic push_grants(input bit [2:0] m);
    bit [2:0] p;
    p = m;
    while (p != 0) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (last_gnt + k) % 3;
        if (p[c]) begin
          exp_gnt.push_back(c);
          p[c] = 1'b0;
          last_gnt = c;
          break;
        end
      end
    end
  endtask
  task automatic push_rd(input int ch, input logic [31:0] a, input int n);
    rd_t e;
    if (n == 0) begin
      e = '{32'h0, 1'b1, 1'b1};
      if (ch == 0) exp_img.push_back(e); else exp_wgt.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e = '{mem(a + 32'(i)), i == n - 1, 1'b0};
      if (ch == 0) exp_img.push_back(e); else exp_wgt.push_back(e);
    end
  endtask
  task automatic push_wr(input logic [31:0] a, input int n);
    logic [31:0] d;
    wr_data_q.delete();
    if (n == 0) exp_wr.push_back('{32'h0, 32'h0, 1'b1, 1'b1});
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      wr_data_q.push_back(d);
      exp_wr.push_back('{a + 32'(i), d, i == n - 1, 1'b0});
    end
  endtask
  task automatic do_req(input int ch, input logic [31:0] a, input int n, input int pat);
    logic got;
    logic v;
    logic [3:0] pb;
    int i;
    got = 1'b0;
    pb = 4'b1101;
    if (ch == 0) begin bus.img_req = 1'b1; bus.img_addr = a; bus.img_len = 12'(n); end
    if (ch == 1) begin bus.wgt_req = 1'b1; bus.wgt_addr = a; bus.wgt_len = 12'(n); end
    if (ch == 2) begin bus.res_req = 1'b1; bus.res_addr = a; bus.res_len = 12'(n); end
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      got = ch == 0 ? bus.img_gnt : ch == 1 ? bus.wgt_gnt : bus.res_gnt;
    end
    if (!got) chk("gnt_timeout", got, 1);
    if (ch == 0) bus.img_req = 1'b0;
    if (ch == 1) bus.wgt_req = 1'b0;
    if (ch == 2) bus.res_req = 1'b0;
    if (ch == 2 && n > 0 && got) begin
      i = 0;
      for (int t = 0; t < 5000 && i < n; t++) begin
        if (t > 0) @(negedge clk);
        v = pat == 1 ? (t < 4 ? pb[t] : 1'b1) : 1'($urandom_range(0, 1));
        bus.res_wr_valid = v;
        bus.res_wr_data = wr_data_q[i];
        if (v && bus.res_wr_ready) i++;
      end
      @(negedge clk);
      bus.res_wr_valid = 1'b0;
    end
  endtask
  task automatic wait_idle();
    int t;
    for (t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (exp_img.size() == 0 && exp_wgt.size() == 0 && exp_wr.size() == 0 &&
          exp_gnt.size() == 0 && pend.size() == 0 && !bus.busy) break;
    end
    if (t == 4000)
      chk("drain_timeout", exp_img.size() + exp_wgt.size() + exp_wr.size() + exp_gnt.size() + int'(bus.busy), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic run_batch(input bit [2:0] m, input logic [31:0] a0, input int n0,
                           input logic [31:0] a1, input int n1, input logic [31:0] a2,
                           input int n2, input int l, input int pat);
    lat = l;
    push_grants(m);
    if (m[0]) push_rd(0, a0, n0);
    if (m[1]) push_rd(1, a1, n1);
    if (m[2]) push_wr(a2, n2);
    fork
      begin if (m[0]) do_req(0, a0, n0, pat); end
      begin if (m[1]) do_req(1, a1, n1, pat); end
      begin if (m[2]) do_req(2, a2, n2, pat); end
    join
    wait_idle();
  endtask
  function automatic logic [31:0] rand_addr();
    return $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
  endfunction
  initial begin
    bus.img_req = 1'b0; bus.img_addr = '0; bus.img_len = '0;
    bus.wgt_req = 1'b0; bus.wgt_addr = '0; bus.wgt_len = '0;
    bus.res_req = 1'b0; bus.res_addr = '0; bus.res_len = '0;
    bus.res_wr_data = '0; bus.res_wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs_any(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", bus.busy, 0);
    run_batch(3'b001, 32'h0, 4, 32'h0, 0, 32'h0, 0, 2, 0);
    run_batch(3'b111, 32'h100, 3, 32'h200, 2, 32'h300, 2, 3, 0);
    run_batch(3'b001, 32'h400, 1, 32'h0, 0, 32'h0, 0, 2, 0);
    run_batch(3'b111, 32'h500, 2, 32'h600, 3, 32'h700, 1, 4, 0);
    run_batch(3'b010, 32'h0, 0, 32'h1000, 10, 32'h0, 0, 8, 0);
    run_batch(3'b100, 32'h0, 0, 32'h0, 0, 32'd34000, 3, 2, 1);
    run_batch(3'b011, 32'h40, 0, 32'h80, 2, 32'h0, 0, 2, 0);
    run_batch(3'b101, 32'hFFFF_FFFE, 4, 32'h0, 0, 32'hFFFF_FFFF, 3, 1, 0);
    chk("err_clear_before_abort", bus.err, 0);
    lat = 10;
    exp_gnt.push_back(0);
    last_gnt = 0;
    do_req(0, 32'h2000, 2, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("two_outstanding_before_abort", pend.size(), 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_outputs_zero", outs_any(), 0);
    rst_n = 1'b1;
    last_gnt = 2;
    for (int t = 0; t < 100 && pend.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("err_late_return", bus.err, 1);
    chk("busy_after_abort", bus.busy, 0);
    run_batch(3'b001, 32'h3000, 3, 32'h0, 0, 32'h0, 0, 2, 0);
    for (int r = 0; r < 25; r++)
      run_batch(3'($urandom_range(1, 7)), rand_addr(), $urandom_range(0, 12), rand_addr(),
                $urandom_range(0, 12), rand_addr(), $urandom_range(0, 12), $urandom_range(1, 8), 0);
    chk("err_sticky", bus.err, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
